// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, even parity, one stop bit.
// One byte per accepted request; frame is 11 * CLK_PER_BIT cycles long.
module uart_tx #(
    parameter int unsigned CLK_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_active,
    output logic       o_tx_serial,
    output logic       o_tx_done
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]    bit_idx, bit_idx_n;
    logic [DATA_W-1:0]   hold, hold_n;
    logic                parity, parity_n;
    logic                serial_n, active_n, done_n;
    logic                bit_last;

    assign bit_last   = (bit_cnt == CNT_LAST);
    assign o_tx_ready = (state == S_IDLE);

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            hold        <= '0;
            parity      <= 1'b0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            bit_idx     <= bit_idx_n;
            hold        <= hold_n;
            parity      <= parity_n;
            o_tx_serial <= serial_n;
            o_tx_active <= active_n;
            o_tx_done   <= done_n;
        end
    end

    // Next-state and next-output logic; serial_n is the line value for the next cycle
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        hold_n    = hold;
        parity_n  = parity;
        serial_n  = 1'b1;
        active_n  = 1'b0;
        done_n    = 1'b0;

        case (state)
            S_IDLE: begin
                bit_cnt_n = '0;
                bit_idx_n = '0;
                if (i_tx_dv) begin
                    hold_n   = i_tx_byte;
                    parity_n = ^i_tx_byte;
                    state_n  = S_START;
                    serial_n = 1'b0;
                    active_n = 1'b1;
                end
            end
            S_START: begin
                active_n = 1'b1;
                serial_n = 1'b0;
                if (bit_last) begin
                    bit_cnt_n = '0;
                    state_n   = S_DATA;
                    serial_n  = hold[0];
                end else begin
                    bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                end
            end
            S_DATA: begin
                active_n = 1'b1;
                serial_n = hold[bit_idx];
                if (bit_last) begin
                    bit_cnt_n = '0;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_n = '0;
                        state_n   = S_PARITY;
                        serial_n  = parity;
                    end else begin
                        bit_idx_n = IDX_W'(bit_idx + 1'b1);
                        serial_n  = hold[bit_idx_n];
                    end
                end else begin
                    bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                end
            end
            S_PARITY: begin
                active_n = 1'b1;
                serial_n = parity;
                if (bit_last) begin
                    bit_cnt_n = '0;
                    state_n   = S_STOP;
                    serial_n  = 1'b1;
                end else begin
                    bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                end
            end
            S_STOP: begin
                active_n = 1'b1;
                serial_n = 1'b1;
                if (bit_last) begin
                    bit_cnt_n = '0;
                    state_n   = S_IDLE;
                    active_n  = 1'b0;
                    done_n    = 1'b1;
                end else begin
                    bit_cnt_n = CNT_W'(bit_cnt + 1'b1);
                end
            end
            default: begin
                state_n   = S_IDLE;
                bit_cnt_n = '0;
                bit_idx_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx, plus a loopback through a bench receiver.
module tb_uart_tx;

    localparam int CPB    = 87;
    localparam int FRAME  = 11 * CPB;
    localparam int CPB_LB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_tx_dv;
    logic [7:0] i_tx_byte;
    logic       o_tx_ready, o_tx_active, o_tx_serial, o_tx_done;

    logic       lb_dv;
    logic [7:0] lb_byte;
    logic       lb_ready, lb_active, lb_serial, lb_done;

    int tests = 0;
    int fails = 0;

    logic obs [FRAME];
    int   bad_hs, done_mid;
    logic end_done, end_ready, end_active, end_serial;

    always #5 clk = ~clk;

    uart_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .i_tx_dv(i_tx_dv), .i_tx_byte(i_tx_byte),
        .o_tx_ready(o_tx_ready), .o_tx_active(o_tx_active),
        .o_tx_serial(o_tx_serial), .o_tx_done(o_tx_done)
    );

    uart_tx #(.CLK_PER_BIT(CPB_LB)) dut_lb (
        .clk(clk), .reset(reset), .i_tx_dv(lb_dv), .i_tx_byte(lb_byte),
        .o_tx_ready(lb_ready), .o_tx_active(lb_active),
        .o_tx_serial(lb_serial), .o_tx_done(lb_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; caller guarantees the DUT is idle.
    task automatic accept(input logic [7:0] b);
        i_tx_dv   = 1'b1;
        i_tx_byte = b;
        tick();
    endtask

    // Record the line for one frame starting at the first cycle after accept.
    task automatic watch_frame(input logic dv_mid, input logic [7:0] byte_mid, input logic dv_end);
        bad_hs    = 0;
        done_mid  = 0;
        i_tx_dv   = dv_mid;
        i_tx_byte = byte_mid;
        for (int n = 0; n < FRAME; n++) begin
            obs[n] = o_tx_serial;
            if (o_tx_active !== 1'b1 || o_tx_ready !== 1'b0) bad_hs++;
            if (o_tx_done !== 1'b0) done_mid++;
            tick();
        end
        end_done   = o_tx_done;
        end_ready  = o_tx_ready;
        end_active = o_tx_active;
        end_serial = o_tx_serial;
        i_tx_dv    = dv_end;
    endtask

    // Cycles in the recorded frame that differ from the ideal waveform of b.
    function automatic int frame_errs(input logic [7:0] b);
        logic [10:0] f;
        int e;
        e = 0;
        f = {1'b1, ^b, b, 1'b0};
        for (int n = 0; n < FRAME; n++)
            if (obs[n] !== f[n / CPB]) e++;
        return e;
    endfunction

    task automatic check_frame_end(input string name, input logic [7:0] b, input logic exp_par);
        int e;
        e = frame_errs(b);
        tests++; if (e !== 0) begin fails++; $display("FAIL %s waveform: %0d bad cycles, required 0", name, e); end
        tests++; if (obs[9*CPB + CPB/2] !== exp_par) begin fails++; $display("FAIL %s parity: got %b, required %b", name, obs[9*CPB + CPB/2], exp_par); end
        tests++; if (bad_hs !== 0) begin fails++; $display("FAIL %s active/ready in frame: %0d bad cycles, required 0", name, bad_hs); end
        tests++; if (done_mid !== 0) begin fails++; $display("FAIL %s early done: %0d cycles, required 0", name, done_mid); end
        tests++; if ({end_done, end_ready, end_active, end_serial} !== 4'b1101) begin
            fails++; $display("FAIL %s frame end done/ready/active/serial: got %b%b%b%b, required 1101",
                              name, end_done, end_ready, end_active, end_serial);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_tx_dv = 1'b0; i_tx_byte = 8'h00; lb_dv = 1'b0; lb_byte = 8'h00;
        tick(); tick(); tick();
        tests++; if ({o_tx_serial, o_tx_ready, o_tx_active, o_tx_done} !== 4'b1100) begin
            fails++; $display("FAIL reset state serial/ready/active/done: got %b%b%b%b, required 1100",
                              o_tx_serial, o_tx_ready, o_tx_active, o_tx_done);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++; if ({o_tx_serial, o_tx_ready, o_tx_active, o_tx_done} !== 4'b1100) begin
                fails++; $display("FAIL idle cycle %0d serial/ready/active/done: got %b%b%b%b, required 1100",
                                  i, o_tx_serial, o_tx_ready, o_tx_active, o_tx_done);
            end
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] b, input logic exp_par);
        accept(b);
        watch_frame(1'b0, ~b, 1'b0);
        check_frame_end(name, b, exp_par);
        tick();
        tests++; if (o_tx_done !== 1'b0 || o_tx_serial !== 1'b1) begin
            fails++; $display("FAIL %s after done: done=%b serial=%b, required done=0 serial=1", name, o_tx_done, o_tx_serial);
        end
    endtask

    task automatic test_back_to_back();
        accept(8'h3C);
        watch_frame(1'b1, 8'hC3, 1'b1);
        check_frame_end("b2b_first", 8'h3C, 1'b0);
        tick();
        watch_frame(1'b0, 8'h00, 1'b0);
        check_frame_end("b2b_second", 8'hC3, 1'b0);
        tick();
    endtask

    task automatic test_ignored_request();
        int extra;
        accept(8'h12);
        watch_frame(1'b1, 8'hFF, 1'b0);
        check_frame_end("ignored_req", 8'h12, 1'b0);
        extra = 0;
        for (int i = 0; i < 3*CPB; i++) begin
            tick();
            if (o_tx_serial !== 1'b1 || o_tx_ready !== 1'b1 || o_tx_done !== 1'b0) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL ignored_req extra frame: %0d bad idle cycles, required 0", extra); end
    endtask

    task automatic test_reset_mid_frame();
        int dn;
        accept(8'h5A);
        i_tx_dv = 1'b0;
        for (int i = 0; i < 4*CPB + 10; i++) tick();
        tests++; if (o_tx_active !== 1'b1 || o_tx_serial !== 1'b1) begin
            fails++; $display("FAIL mid_reset pre data bit3: active=%b serial=%b, required 1 1", o_tx_active, o_tx_serial);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if ({o_tx_serial, o_tx_ready, o_tx_active, o_tx_done} !== 4'b1100) begin
            fails++; $display("FAIL mid_reset after reset serial/ready/active/done: got %b%b%b%b, required 1100",
                              o_tx_serial, o_tx_ready, o_tx_active, o_tx_done);
        end
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_tx_done !== 1'b0 || o_tx_serial !== 1'b1) dn++;
        end
        tests++; if (dn !== 0) begin fails++; $display("FAIL mid_reset stray done/line: %0d cycles, required 0", dn); end
        test_frame("after_reset_55", 8'h55, 1'b0);
    endtask

    task automatic test_loopback();
        logic [7:0] b, rx;
        logic       st, pb, sp;
        int         guard;
        for (int i = 0; i < 256; i++) begin
            guard = 0;
            while (lb_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
            b = 8'($urandom);
            lb_dv = 1'b1; lb_byte = b;
            tick();
            lb_dv = 1'b0; lb_byte = 8'h00;
            guard = 0;
            while (lb_serial !== 1'b0 && guard < 20) begin tick(); guard++; end
            for (int k = 0; k < CPB_LB/2; k++) tick();
            st = lb_serial;
            for (int j = 0; j < 8; j++) begin
                for (int k = 0; k < CPB_LB; k++) tick();
                rx[j] = lb_serial;
            end
            for (int k = 0; k < CPB_LB; k++) tick();
            pb = lb_serial;
            for (int k = 0; k < CPB_LB; k++) tick();
            sp = lb_serial;
            tests++;
            if (st !== 1'b0 || rx !== b || pb !== ^b || sp !== 1'b1) begin
                fails++;
                $display("FAIL loopback %0d: start=%b byte=%h parity=%b stop=%b, required 0 %h %b 1",
                         i, st, rx, pb, sp, b, ^b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame("frame_A5", 8'hA5, 1'b0);
        test_frame("frame_07", 8'h07, 1'b1);
        test_frame("frame_00", 8'h00, 1'b0);
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
